// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes, select constants and control bundle for multicycle_control
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state+mem_rdy to control decode; ADDI states under MC_CTRL_ADDI_EN
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_rdy,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle memory actually returns the word
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM; addi support under MC_CTRL_ADDI_EN
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_rdy,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_next;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;

  // opcode is captured in DECODE so MEM_ADDR can pick lw/sw without re-sampling the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_next = state_q;
    illegal    = 1'b0;
    case (state_q)
      S_RESET:     state_next = S_FETCH;
      S_FETCH:     if (mem_rdy) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_next = S_ADDI_EXEC;
`endif
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_rdy) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_rdy) state_next = S_FETCH;
      S_EXECUTE:   state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_ADDI_WB:   state_next = S_FETCH;
`endif
      default:     state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state   (state_q),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign state         = state_q;

endmodule
